// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
//   fetch_state_e    : controller states
//   PC_RESET_DEFAULT : default first fetch address after reset
//   ibus_req_t       : instruction-bus request (valid + address)
//   ibus_resp_t      : instruction-bus response (data_ok + word)
//   next_seq_pc      : sequential successor of a fetch address
package fetch_ctrl_pkg;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    // Wraps modulo 2^64 by construction of the 64-bit add.
    function automatic logic [63:0] next_seq_pc(input logic [63:0] cur_pc);
        return cur_pc + 64'd4;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding request on the instruction
// bus, a single-entry output register handed to the fetch stage, and
// redirect handling that never withdraws an issued request.
//
// Ports
//   clk, reset                 : clock, async active-high reset
//   ireq_valid, ireq_addr      : instruction-bus request
//   iresp_data_ok, iresp_data  : instruction-bus response
//   redirect_valid, redirect_pc: branch/jump/exception redirect
//   out_ready                  : downstream accepts the held instruction
//   out_valid, raw_instr, pc   : held instruction and its address
//   fetch_cnt                  : instructions handed over (wraps)
//
// state | meaning
// ------+-------------------------------------------------------------
// FETCH | request at pc_q outstanding, waiting for data_ok
// HOLD  | word held in output register, waiting for out_ready
// FLUSH | redirected while request in flight; drain it, then jump
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] raw_instr,
    output logic [63:0] pc,
    output logic [63:0] fetch_cnt
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  target_q, target_d;
    logic [31:0]  raw_instr_q, raw_instr_d;
    logic [63:0]  pc_out_q, pc_out_d;
    logic [63:0]  fetch_cnt_q, fetch_cnt_d;

    ibus_req_t  ireq;
    ibus_resp_t iresp;

    assign iresp.data_ok = iresp_data_ok;
    assign iresp.data    = iresp_data;

    // The request is a function of state only, so address and valid stay
    // stable until the response arrives. It is gated by reset so that a
    // reset mid-request abandons the bus transaction immediately.
    assign ireq.valid = ~reset & (state_q != ST_HOLD);
    assign ireq.addr  = pc_q;

    assign ireq_valid = ireq.valid;
    assign ireq_addr  = ireq.addr;
    assign out_valid  = (state_q == ST_HOLD);
    assign raw_instr  = raw_instr_q;
    assign pc         = pc_out_q;
    assign fetch_cnt  = fetch_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= PC_RESET;
            target_q    <= '0;
            raw_instr_q <= '0;
            pc_out_q    <= '0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            raw_instr_q <= raw_instr_d;
            pc_out_q    <= pc_out_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        target_d    = target_q;
        raw_instr_d = raw_instr_q;
        pc_out_d    = pc_out_q;
        fetch_cnt_d = fetch_cnt_q;

        case (state_q)
            ST_FETCH: begin
                if (redirect_valid && iresp.data_ok) begin
                    // Response already back: drop it and refetch at once.
                    pc_d = redirect_pc;
                end else if (redirect_valid) begin
                    target_d = redirect_pc;
                    state_d  = ST_FLUSH;
                end else if (iresp.data_ok) begin
                    raw_instr_d = iresp.data;
                    pc_out_d    = pc_q;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Redirect wins over out_ready: the held word is wrong-path.
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_FETCH;
                end else if (out_ready) begin
                    pc_d        = next_seq_pc(pc_q);
                    fetch_cnt_d = fetch_cnt_q + 64'd1;
                    state_d     = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                if (iresp.data_ok) begin
                    pc_d    = redirect_valid ? redirect_pc : target_q;
                    state_d = ST_FETCH;
                end else if (redirect_valid) begin
                    target_d = redirect_pc;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a cycle-by-cycle vector table with
// hand-computed outputs, followed by a mid-request reset sequence.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic [63:0] fetch_cnt;

    int n_pass  = 0;
    int n_total = 0;

    fetch_ctrl #(.PC_RESET(64'h0000_0000_8000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .raw_instr      (raw_instr),
        .pc             (pc),
        .fetch_cnt      (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [63:0] rpc;
        logic        dok;
        logic [31:0] data;
        logic        rdy;
        logic        e_iv;
        logic [63:0] e_addr;
        logic        e_ov;
        logic [31:0] e_raw;
        logic [63:0] e_pc;
        logic [63:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] A1  = 32'h1111_0013;
    localparam logic [31:0] A2  = 32'h2222_0013;
    localparam logic [31:0] A3  = 32'h3333_0013;
    localparam logic [31:0] A4  = 32'h4444_0013;
    localparam logic [31:0] A5  = 32'h5555_0013;
    localparam logic [31:0] A6  = 32'h6666_0013;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;
    localparam logic [63:0] B   = 64'h0000_0000_8000_0000;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    task automatic add(input logic rv, input logic [63:0] rpc, input logic dok,
                       input logic [31:0] data, input logic rdy,
                       input logic e_iv, input logic [63:0] e_addr, input logic e_ov,
                       input logic [31:0] e_raw, input logic [63:0] e_pc,
                       input logic [63:0] e_cnt);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.dok = dok; v.data = data; v.rdy = rdy;
        v.e_iv = e_iv; v.e_addr = e_addr; v.e_ov = e_ov;
        v.e_raw = e_raw; v.e_pc = e_pc; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        out_ready      = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        //  rv  rpc                    dok data rdy | iv addr                   ov raw  pc       cnt
        // 1-cycle memory, out_ready=1: handover every third cycle
        add(0, 0,                      0, 0,   1,   1, B,                     0, 0,   0,       0); // 0  FETCH
        add(0, 0,                      1, A1,  1,   1, B,                     0, 0,   0,       0); // 1  FETCH resp
        add(0, 0,                      0, 0,   1,   0, 0,                     1, A1,  B,       0); // 2  HOLD
        add(0, 0,                      0, 0,   1,   1, B+4,                   0, A1,  B,       1); // 3  FETCH
        add(0, 0,                      1, A2,  1,   1, B+4,                   0, A1,  B,       1); // 4
        add(0, 0,                      0, 0,   1,   0, 0,                     1, A2,  B+4,     1); // 5  HOLD
        add(0, 0,                      0, 0,   0,   1, B+8,                   0, A2,  B+4,     2); // 6  FETCH
        // stall 5 cycles in HOLD
        add(0, 0,                      1, A3,  0,   1, B+8,                   0, A2,  B+4,     2); // 7
        add(0, 0,                      0, 0,   0,   0, 0,                     1, A3,  B+8,     2); // 8
        add(0, 0,                      0, 0,   0,   0, 0,                     1, A3,  B+8,     2); // 9
        add(0, 0,                      0, 0,   0,   0, 0,                     1, A3,  B+8,     2); // 10
        add(0, 0,                      0, 0,   0,   0, 0,                     1, A3,  B+8,     2); // 11
        add(0, 0,                      0, 0,   0,   0, 0,                     1, A3,  B+8,     2); // 12
        add(0, 0,                      0, 0,   1,   0, 0,                     1, A3,  B+8,     2); // 13 accept
        // redirect to 0x8000_0100 with response three cycles away
        add(1, B+64'h100,              0, 0,   0,   1, B+12,                  0, A3,  B+8,     3); // 14 -> FLUSH
        add(0, 0,                      0, 0,   0,   1, B+12,                  0, A3,  B+8,     3); // 15 FLUSH
        add(0, 0,                      0, 0,   0,   1, B+12,                  0, A3,  B+8,     3); // 16 FLUSH
        add(0, 0,                      1, BAD, 0,   1, B+12,                  0, A3,  B+8,     3); // 17 drain
        // redirects to 0x200 then 0x300; latest wins
        add(1, 64'h200,                0, 0,   0,   1, B+64'h100,             0, A3,  B+8,     3); // 18 -> FLUSH
        add(1, 64'h300,                0, 0,   0,   1, B+64'h100,             0, A3,  B+8,     3); // 19 overwrite
        add(0, 0,                      1, BAD, 0,   1, B+64'h100,             0, A3,  B+8,     3); // 20 drain
        add(0, 0,                      1, A4,  0,   1, 64'h300,               0, A3,  B+8,     3); // 21 FETCH 0x300
        // redirect + out_ready in HOLD: redirect wins
        add(1, 64'h400,                0, 0,   1,   0, 0,                     1, A4,  64'h300, 3); // 22 HOLD
        // redirect + data_ok together in FETCH: drop, refetch
        add(1, 64'h500,                1, BAD, 0,   1, 64'h400,               0, A4,  64'h300, 3); // 23
        add(0, 0,                      1, A5,  0,   1, 64'h500,               0, A4,  64'h300, 3); // 24
        add(1, TOP,                    0, 0,   0,   0, 0,                     1, A5,  64'h500, 3); // 25 HOLD redir
        add(0, 0,                      1, A6,  0,   1, TOP,                   0, A5,  64'h500, 3); // 26
        add(0, 0,                      0, 0,   1,   0, 0,                     1, A6,  TOP,     3); // 27 handover
        // wrap to 0; then FLUSH with redirect + data_ok together
        add(1, 64'h600,                0, 0,   0,   1, 64'h0,                 0, A6,  TOP,     4); // 28 -> FLUSH
        add(1, 64'h700,                1, BAD, 0,   1, 64'h0,                 0, A6,  TOP,     4); // 29 new target
        add(0, 0,                      0, 0,   0,   1, 64'h700,               0, A6,  TOP,     4); // 30

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset ireq_valid", {63'd0, ireq_valid}, 64'd0);
        chk("reset out_valid",  {63'd0, out_valid},  64'd0);
        chk("reset raw_instr",  {32'd0, raw_instr},  64'd0);
        chk("reset pc",         pc,                  64'd0);
        chk("reset fetch_cnt",  fetch_cnt,           64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            iresp_data_ok  = vecs[i].dok;
            iresp_data     = vecs[i].data;
            out_ready      = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d ireq_valid", i), {63'd0, ireq_valid}, {63'd0, vecs[i].e_iv});
            if (vecs[i].e_iv)
                chk($sformatf("v%0d ireq_addr", i), ireq_addr, vecs[i].e_addr);
            chk($sformatf("v%0d out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
            chk($sformatf("v%0d raw_instr", i), {32'd0, raw_instr}, {32'd0, vecs[i].e_raw});
            chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d fetch_cnt", i), fetch_cnt, vecs[i].e_cnt);
            @(posedge clk);
            #1;
        end

        // Reset pulsed while the request at 0x700 is outstanding.
        idle_inputs();
        chk("pre-reset ireq_valid", {63'd0, ireq_valid}, 64'd1);
        reset = 1'b1;
        #1;
        chk("midreset ireq_valid", {63'd0, ireq_valid}, 64'd0);
        chk("midreset fetch_cnt",  fetch_cnt,           64'd0);
        chk("midreset raw_instr",  {32'd0, raw_instr},  64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("post-reset ireq_valid", {63'd0, ireq_valid}, 64'd1);
        chk("post-reset ireq_addr",  ireq_addr,           B);
        chk("post-reset out_valid",  {63'd0, out_valid},  64'd0);
        // First fetch after reset completes normally.
        iresp_data_ok = 1'b1;
        iresp_data    = A1;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("post-reset out_valid hold", {63'd0, out_valid}, 64'd1);
        chk("post-reset pc hold",        pc,                 B);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_RESET, default 64'h8000_0000: first fetch address after reset.
REQ-002 SHALL have ports clk (in, 1, clock) and reset (in, 1): one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port ireq_valid (out, 1): instruction-bus request.
REQ-004 SHALL have port ireq_addr (out, 64): request address.
REQ-005 SHALL have port iresp_data_ok (in, 1): response valid this cycle.
REQ-006 SHALL have port iresp_data (in, 32): instruction word.
REQ-007 SHALL have port redirect_valid (in, 1): branch/jump/exception redirect.
REQ-008 SHALL have port redirect_pc (in, 64): redirect target.
REQ-009 SHALL have port out_ready (in, 1): fetch stage accepts the held instruction.
REQ-010 SHALL have port out_valid (out, 1): raw_instr/pc valid.
REQ-011 SHALL have port raw_instr (out, 32): fetched word.
REQ-012 SHALL have port pc (out, 64): address of raw_instr.
REQ-013 SHALL have port fetch_cnt (out, 64): count of instructions handed over.

Function
REQ-014 SHALL implement states FETCH, HOLD and FLUSH, with at most one bus request outstanding.
REQ-015 In FETCH, SHALL drive ireq_valid=1 and ireq_addr=pc_q, both stable until iresp_data_ok.
REQ-016 FETCH + data_ok + no redirect SHALL latch iresp_data and pc_q into the output register and go to HOLD; out_valid SHALL assert the next cycle.
REQ-017 In HOLD, SHALL drive ireq_valid=0 and out_valid=1, holding raw_instr/pc stable.
REQ-018 HOLD + out_ready + no redirect SHALL apply pc_q<=pc_q+4, increment fetch_cnt and go to FETCH; ireq_valid SHALL assert the next cycle.
REQ-019 SHALL compute pc_q+4 modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
REQ-020 FETCH + redirect + data_ok in the same cycle SHALL discard the data, set pc_q<=redirect_pc and stay in FETCH.
REQ-021 FETCH + redirect + no data_ok SHALL record the target and enter FLUSH.
REQ-022 In FLUSH, SHALL keep ireq_valid=1 with the old address (no request withdrawal) and out_valid=0.
REQ-023 FLUSH + data_ok SHALL discard the data, set pc_q<=target and go to FETCH.
REQ-024 A further redirect in FLUSH SHALL overwrite the target (latest wins); redirect and data_ok together SHALL use the new redirect_pc.
REQ-025 HOLD + redirect SHALL drop out_valid next cycle, set pc_q<=redirect_pc and go to FETCH; it SHALL override out_ready and SHALL NOT increment fetch_cnt.
REQ-026 SHALL never deliver a discarded word to out_valid.
REQ-027 SHALL pass redirect_pc through unmodified; alignment checking belongs downstream.
REQ-028 fetch_cnt SHALL wrap modulo 2^64.

Reset
REQ-029 While reset=1, SHALL force state=FETCH, pc_q=PC_RESET, out_valid=0, raw_instr=0, pc=0, fetch_cnt=0 and ireq_valid=0.
REQ-030 Reset asserted mid-request SHALL abandon the request with no flush; ireq_valid SHALL reassert with ireq_addr=PC_RESET on the first cycle after deassertion.

Structure
REQ-031 SHALL place the state enum and the PC_RESET default in the shared common package; the instruction-bus fields SHALL use the shared bus request/response typedefs.
REQ-032 SHALL be a single module, with no sub-module.

Verification
REQ-033 Bench SHALL cover: reset, 1-cycle-latency memory, out_ready=1 -> ireq_addr 0x8000_0000, then 0x8000_0004; out_valid every 3rd cycle; fetch_cnt=2 after two handovers.
REQ-034 Bench SHALL cover: out_ready=0 for 5 cycles in HOLD -> raw_instr/pc stable, ireq_valid=0, fetch_cnt unchanged.
REQ-035 Bench SHALL cover: redirect to 0x8000_0100 while data_ok is 3 cycles away -> FLUSH; old word dropped; next ireq_addr=0x8000_0100.
REQ-036 Bench SHALL cover: redirects to 0x200 then 0x300 during FLUSH -> next fetch at 0x300.
REQ-037 Bench SHALL cover: redirect and out_ready together in HOLD -> no handover, fetch_cnt unchanged, next ireq_addr=redirect_pc.
REQ-038 Bench SHALL cover: redirect to 0xFFFF_FFFF_FFFF_FFFC with handover -> next ireq_addr=0; reset pulsed mid-request -> ireq_addr=PC_RESET on the first cycle after deassertion.
